hiscore_ram_arbiter: RTL and testbench
======================================

Name: hiscore_ram_arbiter

Overview:
- Shares the game's single-port work RAM between the running CPU and the hiscore engine.
- On hiscore access intent: requests a CPU pause through the pause system, waits for the pause acknowledge plus a settle window, then grants the RAM port to the hiscore engine.
- When the intent drops, returns the RAM port to the CPU and releases the pause.
- Sits between the hiscore module, the pause module and the exidy2 core RAM port.

Parameters:
ADDR_W, 16, RAM address width (matches hs_address).
DATA_W, 8, RAM data width.
SETTLE, 4, cycles to wait after paused is seen before the hiscore engine owns the RAM (1..15).

Ports:
clk_sys  in  1  system clock (45 MHz domain)
reset  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  CPU RAM address
cpu_wdata  in  DATA_W  CPU write data
cpu_we  in  1  CPU write strobe
cpu_rdata  out  DATA_W  RAM read data to CPU
hs_address  in  ADDR_W  hiscore RAM address
hs_data_in  in  DATA_W  hiscore write data
hs_write  in  1  hiscore write strobe
hs_access_read  in  1  hiscore read intent
hs_access_write  in  1  hiscore write intent
hs_data_out  out  DATA_W  RAM read data to hiscore
paused  in  1  CPU-paused acknowledge from pause module
pause_req  out  1  pause request to pause module (registered)
hs_grant  out  1  hiscore owns the RAM port (registered)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data (synchronous RAM, 1-cycle latency)

Behaviour:
- Signal: intent = hs_access_read | hs_access_write.
- FSM states: IDLE, REQ, SETTLE, GRANT, RELEASE. Reset value: IDLE.
- Outputs at reset: pause_req=0, hs_grant=0, settle counter=0. Reset is honoured mid-operation in any state; the next cycle is IDLE with the CPU owning the RAM.
- IDLE:
  - CPU owns the port; pause_req=0.
  - intent=1 -> REQ.
- REQ:
  - pause_req=1; CPU still owns the port.
  - paused=1 -> SETTLE with counter cleared.
  - intent=0 -> RELEASE (request withdrawn).
  - No timeout: REQ waits indefinitely.
- SETTLE:
  - pause_req=1; the port is parked: ram_addr=hs_address, ram_we=0.
  - The counter increments each cycle; when counter==SETTLE-1 -> GRANT.
  - paused=0 -> REQ.
  - intent=0 -> RELEASE.
- GRANT:
  - hs_grant=1, pause_req=1.
  - ram_addr=hs_address, ram_wdata=hs_data_in, ram_we=hs_write & hs_access_write.
  - A write strobe without write intent is ignored.
  - intent=0 -> RELEASE.
  - paused=0 (external unpause) -> REQ, with ram_we forced 0 in that same cycle.
- RELEASE:
  - Lasts exactly 1 cycle; pause_req=0, hs_grant=0; CPU owns the port.
  - Always -> IDLE; intent present during RELEASE is only acted on from IDLE.
- CPU ownership (IDLE, REQ, RELEASE): ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we.
- CPU writes are dropped in SETTLE and GRANT.
- Mux outputs are combinational from the registered state. cpu_rdata and hs_data_out both equal ram_rdata. Read data is valid one cycle after the address is presented.
- Latency: intent assert -> pause_req high is 1 cycle. paused seen in REQ -> hs_grant high is SETTLE+1 cycles.
- Simultaneous paused=1 and intent=0 in REQ: the intent drop wins -> RELEASE.

Test Plan:
- Reset: hold reset 3 cycles mid-GRANT -> pause_req=0, hs_grant=0, ram_we follows cpu_we, state IDLE.
- Basic read, SETTLE=4:
  - Stimulus: assert hs_access_read at t0; paused rises at t3; hs_address=0x1234; RAM preloaded with 0xA5.
  - Expect: pause_req=1 at t1; hs_grant=1 at t8; ram_addr=0x1234; hs_data_out=0xA5 one cycle later.
- Write gating:
  - In GRANT with hs_access_write=1, hs_write pulse, hs_data_in=0x5A at 0x0040 -> one ram_we cycle, RAM[0x0040]=0x5A.
  - Same pulse with hs_access_write=0 -> no ram_we.
- CPU lockout: cpu_we=1 at cpu_addr=0x0040 during SETTLE/GRANT -> ram_we=0, RAM unchanged. In IDLE the same write lands.
- Abort paths:
  - Intent drops in REQ -> RELEASE 1 cycle, then IDLE, pause_req=0.
  - paused drops in GRANT -> hs_grant=0 and ram_we=0 that cycle, state REQ, pause_req stays 1.
- Back-to-back: intent re-asserted during RELEASE -> IDLE for 1 cycle, then REQ. pause_req shows a 2-cycle low gap.

Source files
------------

// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter
//   Shares the game's single-port work RAM between the running CPU and the
//   hiscore engine. When the hiscore engine signals read or write intent, the
//   arbiter asks the pause module to stop the CPU. It waits for the paused
//   acknowledge plus a settle window, then hands the RAM port to the hiscore
//   engine. When the intent drops, it returns the port to the CPU and releases
//   the pause.
//
// Ports
//   clk_sys, reset          system clock, synchronous active-high reset
//   cpu_addr/wdata/we       CPU side of the RAM port; cpu_rdata returns data
//   hs_address/data_in      hiscore address and write data; hs_write strobe
//   hs_access_read/write    hiscore read / write intent; hs_data_out returns data
//   paused, pause_req       handshake with the pause module (pause_req registered)
//   hs_grant                hiscore engine owns the RAM port (registered)
//   ram_addr/wdata/we       muxed RAM port; ram_rdata has 1-cycle latency
module hiscore_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int SETTLE = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [DATA_W-1:0] hs_data_out,
  input  logic              paused,
  output logic              pause_req,
  output logic              hs_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pause_req_q, pause_req_d;
  logic       hs_grant_q, hs_grant_d;
  logic       intent;

  assign intent = hs_access_read | hs_access_write;

  // Next-state logic. Losing the intent always wins over every other event,
  // so a withdrawn request goes through RELEASE even if paused arrives late.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (intent) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!intent) begin
          state_d = ST_RELEASE;
        end else if (paused) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!intent) begin
          state_d = ST_RELEASE;
        end else if (!paused) begin
          state_d = ST_REQ;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_GRANT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GRANT: begin
        if (!intent)      state_d = ST_RELEASE;
        else if (!paused) state_d = ST_REQ;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // The handshake outputs are registered copies of the next state's decode.
    pause_req_d = (state_d == ST_REQ) || (state_d == ST_SETTLE) || (state_d == ST_GRANT);
    hs_grant_d  = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pause_req_q <= 1'b0;
      hs_grant_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pause_req_q <= pause_req_d;
      hs_grant_q  <= hs_grant_d;
    end
  end

  assign pause_req = pause_req_q;
  assign hs_grant  = hs_grant_q;

  // Port mux, decoded from the registered state. SETTLE parks the port on the
  // hiscore address with writes off. In GRANT a write needs both the strobe
  // and write intent, and it is suppressed the moment the CPU is unpaused.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we;
    unique case (state_q)
      ST_SETTLE: begin
        ram_addr  = hs_address;
        ram_wdata = hs_data_in;
        ram_we    = 1'b0;
      end
      ST_GRANT: begin
        ram_addr  = hs_address;
        ram_wdata = hs_data_in;
        ram_we    = hs_write & hs_access_write & paused;
      end
      default: ;
    endcase
  end

  assign cpu_rdata   = ram_rdata;
  assign hs_data_out = ram_rdata;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed testbench for hiscore_ram_arbiter (SETTLE = 4). A behavioural
// synchronous RAM with 1-cycle read latency sits on the muxed port. Inputs are
// driven 1 ns after the rising edge. Checks run 2 ns after the edge.
module tb_hiscore_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic        hs_access_read;
  logic        hs_access_write;
  logic [7:0]  hs_data_out;
  logic        paused;
  logic        pause_req;
  logic        hs_grant;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  hiscore_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .SETTLE(4)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_we         (cpu_we),
    .cpu_rdata      (cpu_rdata),
    .hs_address     (hs_address),
    .hs_data_in     (hs_data_in),
    .hs_write       (hs_write),
    .hs_access_read (hs_access_read),
    .hs_access_write(hs_access_write),
    .hs_data_out    (hs_data_out),
    .paused         (paused),
    .pause_req      (pause_req),
    .hs_grant       (hs_grant),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_rdata      (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (the input drive point).
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;

    reset = 1'b1;
    cpu_addr = 16'h0010; cpu_wdata = 8'h00; cpu_we = 1'b0;
    hs_address = 16'h0000; hs_data_in = 8'h00; hs_write = 1'b0;
    hs_access_read = 1'b0; hs_access_write = 1'b0; paused = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state: no request, CPU owns the port.
    cpu_we = 1'b1; cpu_wdata = 8'h11;
    #1;
    check("rst_pause_req", pause_req, 0);
    check("rst_hs_grant", hs_grant, 0);
    check("rst_ram_we_cpu", ram_we, 1);
    check("rst_ram_addr_cpu", ram_addr, 16'h0010);
    cyc();
    cpu_we = 1'b0;

    // Basic read. t0: intent asserted while IDLE.
    hs_address = 16'h1234; hs_access_read = 1'b1;
    #1;
    check("t0_pause_req", pause_req, 0);
    cyc();  // t1
    #1;
    check("t1_pause_req", pause_req, 1);
    check("t1_hs_grant", hs_grant, 0);
    check("t1_cpu_owns", ram_addr, 16'h0010);
    cyc();  // t2
    cyc();  // t3
    paused = 1'b1;
    #1;
    check("t3_pause_req", pause_req, 1);
    cyc();  // t4: SETTLE. A CPU write here must be dropped.
    cpu_addr = 16'h0040; cpu_wdata = 8'hEE; cpu_we = 1'b1;
    #1;
    check("t4_settle_addr", ram_addr, 16'h1234);
    check("t4_settle_we", ram_we, 0);
    check("t4_hs_grant", hs_grant, 0);
    cyc(); cyc(); cyc();  // t7
    #1;
    check("t7_hs_grant", hs_grant, 0);
    cyc();  // t8
    #1;
    check("t8_hs_grant", hs_grant, 1);
    check("t8_ram_addr", ram_addr, 16'h1234);
    check("t8_cpu_we_dropped", ram_we, 0);
    cyc();  // t9
    #1;
    check("t9_hs_data_out", hs_data_out, 8'hA5);
    check("t9_cpu_rdata", cpu_rdata, 8'hA5);

    // Write with write intent: exactly one ram_we cycle.
    hs_access_read = 1'b0; hs_access_write = 1'b1;
    hs_address = 16'h0040; hs_data_in = 8'h5A; hs_write = 1'b1;
    #1;
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_wdata", ram_wdata, 8'h5A);
    cyc();
    hs_write = 1'b0;
    #1;
    check("wr_ram_we_off", ram_we, 0);
    check("wr_mem_0040", mem[16'h0040], 8'h5A);
    cyc();
    #1;
    check("wr_readback", hs_data_out, 8'h5A);

    // Write strobe without write intent is ignored.
    hs_access_write = 1'b0; hs_access_read = 1'b1;
    hs_data_in = 8'h77; hs_write = 1'b1;
    #1;
    check("nointent_ram_we", ram_we, 0);
    cyc();
    hs_write = 1'b0;
    #1;
    check("nointent_mem", mem[16'h0040], 8'h5A);
    cpu_we = 1'b0;

    // External unpause in GRANT: write blocked in the same cycle.
    hs_access_write = 1'b1; hs_write = 1'b1; paused = 1'b0;
    #1;
    check("unpause_ram_we", ram_we, 0);
    check("unpause_grant_still", hs_grant, 1);
    cyc();  // REQ
    hs_write = 1'b0; hs_access_write = 1'b0;
    #1;
    check("unpause_hs_grant", hs_grant, 0);
    check("unpause_pause_req", pause_req, 1);
    check("unpause_cpu_owns", ram_addr, 16'h0040);
    check("unpause_mem", mem[16'h0040], 8'h5A);

    // Intent drops in REQ, re-asserted during RELEASE.
    hs_access_read = 1'b0;
    cyc();  // RELEASE
    hs_access_read = 1'b1;
    #1;
    check("rel_pause_req", pause_req, 0);
    check("rel_hs_grant", hs_grant, 0);
    cyc();  // IDLE
    #1;
    check("idle_gap_pause_req", pause_req, 0);
    cyc();  // REQ
    #1;
    check("rereq_pause_req", pause_req, 1);

    // Bring it back up to GRANT, then reset for 3 cycles mid-GRANT.
    paused = 1'b1;
    cyc(); cyc(); cyc(); cyc(); cyc();
    #1;
    check("regrant_hs_grant", hs_grant, 1);
    reset = 1'b1; hs_access_read = 1'b0;
    cpu_addr = 16'h0050; cpu_wdata = 8'h33; cpu_we = 1'b1;
    cyc();
    #1;
    check("midrst_pause_req", pause_req, 0);
    check("midrst_hs_grant", hs_grant, 0);
    check("midrst_ram_we", ram_we, 1);
    check("midrst_ram_addr", ram_addr, 16'h0050);
    cyc(); cyc();
    reset = 1'b0; cpu_we = 1'b0; paused = 1'b0;
    cyc();

    // CPU write in IDLE lands.
    cpu_addr = 16'h0040; cpu_wdata = 8'h99; cpu_we = 1'b1;
    #1;
    check("idle_pause_req", pause_req, 0);
    check("idle_cpu_ram_we", ram_we, 1);
    cyc();
    cpu_we = 1'b0;
    #1;
    check("idle_cpu_mem", mem[16'h0040], 8'h99);
    check("rst_cpu_mem", mem[16'h0050], 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
